inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_inst_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// inst_sequencer -- sequences one compute tile for the PE core.
// Streams len_nij activation words into xmem (LOAD_X), replays them from xmem
// into L0 (READ_X), runs the array for len_nij cycles (EXEC), then drains
// len_onij output words from the OFIFO into psum memory (DRAIN), and pulses done.
// Ports:
//   clk, reset       : single rising-edge clock, synchronous active-low reset
//   start            : one-cycle request to run a tile (honoured in IDLE only)
//   D_in/D_in_valid  : upstream activation stream, D_in_ready = accept this cycle
//   ofifo_valid      : core output FIFO holds a word
//   inst             : registered 34-bit core instruction word
//   D_xmem           : registered xmem write data
//   busy, done       : not-IDLE flag, one-cycle completion pulse
module inst_sequencer #(
  parameter int bw        = 4,
  parameter int row       = 8,
  parameter int len_nij   = 36,
  parameter int len_onij  = 16,
  parameter int pmem_base = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [bw*row-1:0] D_in,
  input  logic              D_in_valid,
  output logic              D_in_ready,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic [bw*row-1:0] D_xmem,
  output logic              busy,
  output logic              done
);

  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  typedef enum logic [2:0] {IDLE, LOAD_X, READ_X, EXEC, DRAIN, DONE} state_t;

  // Counter carries one bit beyond the 11-bit address so READ_X can reach
  // cnt == len_nij even when len_nij is 2048; addresses use the low 11 bits.
  localparam logic [11:0] NIJ   = 12'(len_nij);
  localparam logic [11:0] ONIJ  = 12'(len_onij);
  localparam logic [10:0] PBASE = 11'(pmem_base);

  function automatic inst_t idle_word();
    inst_t w;
    w          = '0;
    w.cen_pmem = 1'b1;
    w.wen_pmem = 1'b1;
    w.cen_xmem = 1'b1;
    w.wen_xmem = 1'b1;
    return w;
  endfunction

  state_t              state_q, state_d;
  logic [11:0]         cnt_q, cnt_d;
  logic                ph_q, ph_d;     // DRAIN phase: 0 = sample cycle, 1 = gap cycle
  inst_t               inst_q, inst_d;
  logic [bw*row-1:0]   dx_q, dx_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      inst_q  <= idle_word();
      dx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      inst_q  <= inst_d;
      dx_q    <= dx_d;
    end
  end

  // Next-state / counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_X;
        cnt_d   = '0;
      end
      LOAD_X: if (D_in_valid) begin
        if (cnt_q == NIJ - 12'd1) begin
          state_d = READ_X;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      READ_X: begin
        // len_nij reads plus one trailing cycle for the last L0 write
        if (cnt_q == NIJ) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      EXEC: begin
        if (cnt_q == NIJ - 12'd1) begin
          state_d = DRAIN;
          cnt_d   = '0;
          ph_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      DRAIN: begin
        if (!ph_q) begin
          if (ofifo_valid) begin
            cnt_d = cnt_q + 12'd1;
            ph_d  = 1'b1;
          end
        end else begin
          ph_d = 1'b0;
          if (cnt_q == ONIJ) begin
            state_d = DONE;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ph_d    = 1'b0;
      end
    endcase
  end

  // Registered output words
  always_comb begin
    inst_d = idle_word();
    dx_d   = dx_q;
    unique case (state_q)
      LOAD_X: if (D_in_valid) begin
        inst_d.cen_xmem = 1'b0;
        inst_d.wen_xmem = 1'b0;
        inst_d.a_xmem   = cnt_q[10:0];
        dx_d            = D_in;
      end
      READ_X: begin
        if (cnt_q < NIJ) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = cnt_q[10:0];
        end
        // xmem has one cycle of read latency, so L0 captures one step behind
        if (cnt_q != 12'd0) inst_d.l0_wr = 1'b1;
      end
      EXEC: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
      end
      DRAIN: if (!ph_q && ofifo_valid) begin
        inst_d.ofifo_rd = 1'b1;
        inst_d.cen_pmem = 1'b0;
        inst_d.wen_pmem = 1'b0;
        inst_d.a_pmem   = PBASE + cnt_q[10:0];  // wraps mod 2048
      end
      default: ;
    endcase
  end

  assign inst       = inst_q;
  assign D_xmem     = dx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign D_in_ready = (state_q == LOAD_X);

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;
  localparam int N    = 36;
  localparam int M    = 16;
  localparam int PB   = 100;
  localparam int PB2  = 2040;
  localparam int MAXC = 3000;
  localparam logic [6:0] L0W = 7'b0000100;
  localparam logic [6:0] EXW = 7'b0001010;
  localparam logic [6:0] OFR = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset, start, D_in_valid, ofifo_valid;
  logic [31:0] D_in;
  logic        D_in_ready, busy, done;
  logic [33:0] inst;
  logic [31:0] D_xmem;
  logic        D_in_ready2, busy2, done2;
  logic [33:0] inst2;
  logic [31:0] D_xmem2;

  int checks = 0;
  int passed = 0;

  logic [33:0] lw[$], lw2[$], ew[$];
  logic [31:0] ldx[$], accq[$];
  logic        lbusy[$], ldone[$], lov[$], ebusy[$], edone[$];
  int          acci[$];

  always #5 clk = ~clk;

  inst_sequencer #(.bw(4), .row(8), .len_nij(N), .len_onij(M), .pmem_base(PB)) dut (
    .clk(clk), .reset(reset), .start(start), .D_in(D_in), .D_in_valid(D_in_valid),
    .D_in_ready(D_in_ready), .ofifo_valid(ofifo_valid), .inst(inst), .D_xmem(D_xmem),
    .busy(busy), .done(done));

  // Short tile whose psum window straddles the 2048 wrap point
  inst_sequencer #(.bw(4), .row(8), .len_nij(4), .len_onij(M), .pmem_base(PB2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .D_in(D_in), .D_in_valid(D_in_valid),
    .D_in_ready(D_in_ready2), .ofifo_valid(ofifo_valid), .inst(inst2), .D_xmem(D_xmem2),
    .busy(busy2), .done(done2));

  // Instruction word assembled from the documented bit map
  function automatic logic [33:0] mkw(input logic cx, input logic wx, input logic [10:0] ax,
                                      input logic cp, input logic wp, input logic [10:0] ap,
                                      input logic [6:0] lo);
    return {1'b0, cp, wp, ap, cx, wx, ax, lo};
  endfunction

  function automatic logic [33:0] idle_w();
    return mkw(1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0);
  endfunction

  // Timeline model: beat acceptance times and ofifo history determine the
  // whole tile. Index i = sample taken just after rising edge i (edge 0 = start).
  function automatic void build_expected(input int PBx);
    int n, L, p, q, d;
    n = lw.size();
    ew.delete(); ebusy.delete(); edone.delete();
    for (int i = 0; i < n; i++) begin
      ew.push_back(idle_w()); ebusy.push_back(1'b0); edone.push_back(1'b0);
    end
    if (acci.size() < N) return;
    for (int k = 0; k < N; k++)
      if (acci[k] < n) ew[acci[k]] = mkw(1'b0, 1'b0, 11'(k), 1'b1, 1'b1, 11'd0, 7'd0);
    L = acci[N-1];
    for (int k = 0; k <= N; k++)
      if (L + 1 + k < n)
        ew[L+1+k] = mkw((k < N) ? 1'b0 : 1'b1, 1'b1, (k < N) ? 11'(k) : 11'd0,
                        1'b1, 1'b1, 11'd0, (k >= 1) ? L0W : 7'd0);
    for (int k = 0; k < N; k++)
      if (L + N + 2 + k < n) ew[L+N+2+k] = mkw(1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, EXW);
    p = L + 2*N + 1;
    q = -1;
    for (int m = 0; m < M; m++) begin
      while (p < lov.size() && !lov[p]) p++;
      if (p >= lov.size()) return;
      q = p + 1;
      if (q < n) ew[q] = mkw(1'b1, 1'b1, 11'd0, 1'b0, 1'b0, 11'((PBx + m) % 2048), OFR);
      p = p + 2;
    end
    d = q + 1;
    for (int i = 0; i <= d && i < n; i++) ebusy[i] = 1'b1;
    if (d < n) edone[d] = 1'b1;
  endfunction

  // Runs one tile from IDLE, logging outputs each cycle until 4 cycles past done.
  // pv < 0 means D_in_valid alternates 1,0,1,0.
  task automatic run_tile(input int pv, input int po, input bit poke);
    int i, post;
    lw.delete(); lw2.delete(); ldx.delete(); lbusy.delete(); ldone.delete();
    lov.delete(); accq.delete(); acci.delete();
    start = 1'b1; D_in_valid = 1'b0; ofifo_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; i = 0; post = 0;
    while (1) begin
      lw.push_back(inst); lw2.push_back(inst2); ldx.push_back(D_xmem);
      lbusy.push_back(busy); ldone.push_back(done);
      if (done || post > 0) post++;
      if (post > 4 || i >= MAXC) break;
      D_in        = $urandom;
      D_in_valid  = (post == 0) && ((pv < 0) ? (i % 2 == 0) : ($urandom_range(99) < pv));
      ofifo_valid = (post == 0) && ($urandom_range(99) < po);
      start       = poke && (post == 1 || (post == 0 && $urandom_range(3) == 0));
      if (D_in_ready && D_in_valid) begin accq.push_back(D_in); acci.push_back(i + 1); end
      lov.push_back(ofifo_valid);
      @(posedge clk); #1;
      i++;
    end
    start = 1'b0; D_in_valid = 1'b0; ofifo_valid = 1'b0;
    if (post == 0) begin
      checks++;
      $display("FAIL tile_timeout: no done within %0d cycles", MAXC);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; D_in_valid = 1'b1; ofifo_valid = 1'b1; D_in = 32'hdeadbeef;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inst !== idle_w()) $display("FAIL reset_inst: got %h want %h", inst, idle_w()); else passed++;
    checks++; if (D_xmem !== 32'd0) $display("FAIL reset_dxmem: got %h want 0", D_xmem); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (D_in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", D_in_ready); else passed++;
    checks++; if ({busy2, done2, D_in_ready2} !== 3'b000 || D_xmem2 !== 32'd0)
      $display("FAIL reset_dut2: busy=%b done=%b rdy=%b dx=%h want 0", busy2, done2, D_in_ready2, D_xmem2);
    else passed++;
    reset = 1'b1; start = 1'b0; D_in_valid = 1'b0; ofifo_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_start_ignored: busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_full_tile();
    int pidx[$];
    int c2;
    logic [33:0] w;
    run_tile(100, 100, 1'b0);
    build_expected(PB);
    checks++; if (acci.size() !== N) $display("FAIL full_beats: got %0d want %0d", acci.size(), N); else passed++;
    for (int k = 0; k < acci.size(); k++) begin
      checks++;
      if (acci[k] !== k + 1 || ldx[acci[k]] !== accq[k])
        $display("FAIL full_write[%0d]: at %0d data %h, want at %0d data %h", k, acci[k], ldx[acci[k]], k + 1, accq[k]);
      else passed++;
    end
    for (int i = 0; i < lw.size(); i++) begin
      checks++;
      if (lw[i] !== ew[i] || lbusy[i] !== ebusy[i] || ldone[i] !== edone[i])
        $display("FAIL full_stream[%0d]: inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
                 i, lw[i], lbusy[i], ldone[i], ew[i], ebusy[i], edone[i]);
      else passed++;
    end
    for (int i = 0; i < lw.size(); i++) begin
      w = lw[i];
      if (w[32] == 1'b0) pidx.push_back(i);
    end
    checks++; if (pidx.size() !== M) $display("FAIL full_pmem_count: got %0d want %0d", pidx.size(), M); else passed++;
    for (int j = 1; j < pidx.size(); j++) begin
      checks++;
      if (pidx[j] - pidx[j-1] !== 2) $display("FAIL full_pmem_gap[%0d]: got %0d want 2", j, pidx[j] - pidx[j-1]);
      else passed++;
    end
    c2 = 0;
    for (int i = 0; i < lw2.size(); i++) begin
      w = lw2[i];
      if (w[32] == 1'b0) begin
        checks++;
        if (w[30:20] !== 11'((PB2 + c2) % 2048))
          $display("FAIL wrap_addr[%0d]: got %0d want %0d", c2, w[30:20], (PB2 + c2) % 2048);
        else passed++;
        c2++;
      end
    end
    checks++; if (c2 !== M) $display("FAIL wrap_count: got %0d want %0d", c2, M); else passed++;
  endtask

  task automatic test_load_gaps();
    run_tile(-1, 80, 1'b0);
    build_expected(PB);
    checks++; if (acci.size() !== N) $display("FAIL gaps_beats: got %0d want %0d", acci.size(), N); else passed++;
    for (int k = 0; k < acci.size(); k++) begin
      checks++;
      if (ldx[acci[k]] !== accq[k]) $display("FAIL gaps_data[%0d]: got %h want %h", k, ldx[acci[k]], accq[k]);
      else passed++;
    end
    for (int i = 0; i < lw.size(); i++) begin
      checks++;
      if (lw[i] !== ew[i] || lbusy[i] !== ebusy[i] || ldone[i] !== edone[i])
        $display("FAIL gaps_stream[%0d]: inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
                 i, lw[i], lbusy[i], ldone[i], ew[i], ebusy[i], edone[i]);
      else passed++;
    end
  endtask

  task automatic test_drain_stall();
    run_tile(60, 25, 1'b0);
    build_expected(PB);
    for (int i = 0; i < lw.size(); i++) begin
      checks++;
      if (lw[i] !== ew[i] || lbusy[i] !== ebusy[i] || ldone[i] !== edone[i])
        $display("FAIL stall_stream[%0d]: inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
                 i, lw[i], lbusy[i], ldone[i], ew[i], ebusy[i], edone[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_exec();
    int ex, t;
    logic [33:0] w;
    start = 1'b1; D_in_valid = 1'b1; D_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0; ex = 0; t = 0;
    while (ex < 10 && t < 500) begin
      D_in = $urandom;
      @(posedge clk); #1;
      t++;
      if (inst[1]) ex++;
    end
    checks++; if (ex !== 10) $display("FAIL midexec_reach: exec cycles %0d want 10", ex); else passed++;
    reset = 1'b0; D_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (inst !== idle_w()) $display("FAIL midexec_inst: got %h want %h", inst, idle_w()); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || D_in_ready !== 1'b0)
      $display("FAIL midexec_flags: busy=%b done=%b rdy=%b want 0", busy, done, D_in_ready);
    else passed++;
    checks++; if (D_xmem !== 32'd0) $display("FAIL midexec_dxmem: got %h want 0", D_xmem); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    run_tile(100, 100, 1'b0);
    build_expected(PB);
    w = (acci.size() > 0 && acci[0] < lw.size()) ? lw[acci[0]] : 34'd0;
    checks++; if (w[17:7] !== 11'd0 || w[19:18] !== 2'b00)
      $display("FAIL midexec_first_addr: cen/wen=%b addr=%0d want 00 addr 0", w[19:18], w[17:7]);
    else passed++;
    for (int i = 0; i < lw.size(); i++) begin
      checks++;
      if (lw[i] !== ew[i] || lbusy[i] !== ebusy[i] || ldone[i] !== edone[i])
        $display("FAIL midexec_stream[%0d]: inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
                 i, lw[i], lbusy[i], ldone[i], ew[i], ebusy[i], edone[i]);
      else passed++;
    end
  endtask

  task automatic test_start_in_drain();
    int nd;
    run_tile(70, 60, 1'b1);
    build_expected(PB);
    nd = 0;
    foreach (ldone[i]) if (ldone[i]) nd++;
    checks++; if (nd !== 1) $display("FAIL poke_done_count: got %0d want 1", nd); else passed++;
    checks++; if (lbusy[lbusy.size()-1] !== 1'b0) $display("FAIL poke_idle_after: busy=1 want 0"); else passed++;
    for (int i = 0; i < lw.size(); i++) begin
      checks++;
      if (lw[i] !== ew[i] || lbusy[i] !== ebusy[i] || ldone[i] !== edone[i])
        $display("FAIL poke_stream[%0d]: inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
                 i, lw[i], lbusy[i], ldone[i], ew[i], ebusy[i], edone[i]);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; D_in = '0; D_in_valid = 1'b0; ofifo_valid = 1'b0;
    test_reset();
    test_full_tile();
    test_load_gaps();
    test_drain_stall();
    test_reset_mid_exec();
    test_start_in_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
